// File: rtl/pal_cfg_pkg.sv
// Shared types and constants for the PAL configuration loader.
package pal_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    CRC_CHK,
    APPLY,
    DONE
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  function automatic int num_words(input int bits, input int w);
    return (bits + w - 1) / w;
  endfunction

endpackage

// File: rtl/pal_cfg_crc8.sv
// Serial CRC-8 (poly 0x07, init 0x00, MSB-first feedback) over the shifted config bits.
// Only built when PAL_CFG_CRC_EN is defined.
`ifdef PAL_CFG_CRC_EN
module pal_cfg_crc8
  import pal_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      crc <= 8'h00;
    end else if (clear) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? CRC8_POLY : 8'h00);
    end
  end

endmodule
`endif

// File: rtl/pal_cfg_loader.sv
// Serialises a word stream onto the PAL cfg_clk/cfg_bit pins, then pulses cfg_en.
// Optional trailing CRC-8 word check when PAL_CFG_CRC_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | s_ready=1, waiting for the next word (cfg_clk low, cfg_bit held)
// SHIFT   | one bit per cfg_clk period, bit changes on the falling edge
// CRC_CHK | compare received CRC word against the running CRC
// APPLY   | cfg_en high for APPLY_CYC cfg_clk periods, cfg_bit=0
// DONE    | one-cycle done pulse
module pal_cfg_loader
  import pal_cfg_pkg::*;
#(
  parameter int CFG_BITS  = 242,
  parameter int WORD_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int APPLY_CYC = 4
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              cfg_clk,
  output logic              cfg_bit,
  output logic              cfg_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BC_W = $clog2(CFG_BITS + 1);
  localparam int BI_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AC_W = (APPLY_CYC > 1) ? $clog2(APPLY_CYC) : 1;

  localparam logic [HC_W-1:0] HALF_LOAD  = HC_W'(CLK_DIV - 1);
  localparam logic [AC_W-1:0] APPLY_LOAD = AC_W'(APPLY_CYC - 1);

  state_t            state, state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [BC_W-1:0]   bit_cnt;
  logic [BI_W-1:0]   bit_idx;
  logic [HC_W-1:0]   half_cnt;
  logic [AC_W-1:0]   apply_cnt;
  logic              half_tc;
  logic              fall_evt;
  logic              last_bit;
  logic              last_in_word;
  logic              all_sent;
  logic              crc_ok;

  assign half_tc      = (half_cnt == '0);
  assign fall_evt     = half_tc && cfg_clk;
  assign last_bit     = (bit_cnt == BC_W'(CFG_BITS - 1));
  assign last_in_word = (bit_idx == BI_W'(WORD_W - 1));
  assign all_sent     = (bit_cnt == BC_W'(CFG_BITS));

  assign s_ready = (state == FETCH);
  assign busy    = (state == FETCH) || (state == SHIFT) ||
                   (state == CRC_CHK) || (state == APPLY);
  assign done    = (state == DONE);

`ifdef PAL_CFG_CRC_EN
  logic [7:0] crc_val;

  pal_cfg_crc8 u_crc (
    .clk    (clk),
    .res    (res),
    .clear  ((state == IDLE) && start),
    .en     ((state == SHIFT) && fall_evt),
    .bit_in (cfg_bit),
    .crc    (crc_val)
  );

  assign crc_ok = (shreg[7:0] == crc_val);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      err <= 1'b0;
    end else if ((state == IDLE) && start) begin
      err <= 1'b0;
    end else if ((state == CRC_CHK) && !crc_ok) begin
      err <= 1'b1;
    end
  end
`else
  assign crc_ok = 1'b1;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH: begin
        if (s_valid) begin
`ifdef PAL_CFG_CRC_EN
          state_nxt = all_sent ? CRC_CHK : SHIFT;
`else
          state_nxt = SHIFT;
`endif
        end
      end
      SHIFT: begin
        if (fall_evt) begin
          if (last_bit) begin
`ifdef PAL_CFG_CRC_EN
            state_nxt = FETCH;
`else
            state_nxt = APPLY;
`endif
          end else if (last_in_word) begin
            state_nxt = FETCH;
          end
        end
      end
      CRC_CHK: state_nxt = crc_ok ? APPLY : DONE;
      APPLY:   if (fall_evt && (apply_cnt == '0)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      half_cnt  <= '0;
      apply_cnt <= '0;
      cfg_clk   <= 1'b0;
      cfg_bit   <= 1'b0;
      cfg_en    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cfg_en <= (state_nxt == APPLY);
      if (state != APPLY) apply_cnt <= APPLY_LOAD;
      case (state)
        IDLE: begin
          if (start) begin
            bit_cnt <= '0;
            bit_idx <= '0;
          end
        end
        FETCH: begin
          if (s_valid) begin
            bit_idx  <= '0;
            half_cnt <= HALF_LOAD;
            // The CRC word is kept whole; data words pre-shift so shreg[0] is the next bit.
            if (all_sent) begin
              shreg <= s_data;
            end else begin
              shreg   <= s_data >> 1;
              cfg_bit <= s_data[0];
            end
          end
        end
        SHIFT: begin
          if (half_tc) begin
            half_cnt <= HALF_LOAD;
            cfg_clk  <= ~cfg_clk;
            if (cfg_clk) begin
              bit_cnt <= bit_cnt + 1'b1;
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              if (state_nxt == SHIFT) cfg_bit <= shreg[0];
              else if (state_nxt == APPLY) cfg_bit <= 1'b0;
            end
          end else begin
            half_cnt <= half_cnt - 1'b1;
          end
        end
        CRC_CHK: begin
          half_cnt <= HALF_LOAD;
          cfg_clk  <= 1'b0;
          cfg_bit  <= 1'b0;
        end
        APPLY: begin
          if (half_tc) begin
            half_cnt <= HALF_LOAD;
            cfg_clk  <= ~cfg_clk;
            if (cfg_clk) apply_cnt <= apply_cnt - 1'b1;
          end else begin
            half_cnt <= half_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed bench for pal_cfg_loader: default-size instance plus a 9-bit, CLK_DIV=1 instance.
module tb_pal_cfg_loader;

  logic       clk = 1'b0;
  logic       res;
  logic       start, s_valid, s_ready, cfg_clk, cfg_bit, cfg_en, busy, done, err;
  logic [7:0] s_data;
  logic       start_s, s_valid_s, s_ready_s, cfg_clk_s, cfg_bit_s, cfg_en_s, busy_s, done_s, err_s;
  logic [7:0] s_data_s;

  always #5 clk = ~clk;

  pal_cfg_loader u_dut (
    .clk(clk), .res(res), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .cfg_clk(cfg_clk), .cfg_bit(cfg_bit), .cfg_en(cfg_en),
    .busy(busy), .done(done), .err(err)
  );

  pal_cfg_loader #(.CFG_BITS(9), .WORD_W(8), .CLK_DIV(1), .APPLY_CYC(4)) u_small (
    .clk(clk), .res(res), .start(start_s), .s_data(s_data_s), .s_valid(s_valid_s),
    .s_ready(s_ready_s), .cfg_clk(cfg_clk_s), .cfg_bit(cfg_bit_s), .cfg_en(cfg_en_s),
    .busy(busy_s), .done(done_s), .err(err_s)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  logic       exp_bits [0:241];
  logic [7:0] crc_big, crc9;
  int         n_words;

  // Monitor on the falling clk edge, away from the active edge.
  logic       mon_clr = 1'b0;
  logic       prev_clk = 1'b0;
  logic       got_bits [0:255];
  int         nbits, napply, ndone, nhs, en_seen, apply_bad;

  always @(negedge clk) begin
    if (mon_clr) begin
      nbits = 0; napply = 0; ndone = 0; nhs = 0; en_seen = 0; apply_bad = 0;
      prev_clk = cfg_clk;
    end else begin
      if (cfg_clk && !prev_clk) begin
        if (cfg_en) begin
          napply++;
          if (cfg_bit) apply_bad++;
        end else begin
          if (nbits < 256) got_bits[nbits] = cfg_bit;
          nbits++;
        end
      end
      prev_clk = cfg_clk;
      if (done) ndone++;
      if (cfg_en) en_seen++;
      if (s_valid && s_ready) nhs++;
    end
  end

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    int t = 0;
    while (!s_ready && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    ok = s_ready;
  endtask

  // One load on the default instance; stall_after / start_mid / abort_at are word indices or -1.
  task automatic run_load(input int stall_after, input int start_mid, input int abort_at,
                          input logic [7:0] crc_xor);
    bit ok;
    int t;
    clr_mon();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_chk++;
    if (s_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_after_start: s_ready=%b busy=%b required 1 1", s_ready, busy);
    end
    n_chk++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear_on_start: err=%b required 0", err);
    end
    for (int w = 0; w < n_words; w++) begin
      s_data  = (w < 31) ? 8'hA5 : (crc_big ^ crc_xor);
      s_valid = 1'b1;
      wait_ready(ok);
      if (!ok) begin
        n_chk++; n_fail++;
        $display("FAIL fetch_timeout: word %0d never accepted", w);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      if (w == abort_at) begin
        repeat (6) @(posedge clk);
        #1 res = 1'b1;
        #1;
        n_chk++;
        if ({cfg_clk, cfg_en, busy, s_ready} !== 4'b0000) begin
          n_fail++;
          $display("FAIL reset_mid_load: clk/en/busy/ready=%b required 0000",
                   {cfg_clk, cfg_en, busy, s_ready});
        end
        @(posedge clk); #1 res = 1'b0;
        return;
      end
      if (w == stall_after) begin
        for (int i = 0; i < 50; i++) begin
          @(posedge clk); #1;
          if (s_ready) begin
            n_chk++;
            if (cfg_clk !== 1'b0 || cfg_bit !== 1'b1) begin
              n_fail++;
              $display("FAIL stall_hold: cfg_clk=%b cfg_bit=%b required 0 1", cfg_clk, cfg_bit);
            end
          end
        end
      end
      if (w == start_mid) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    t = 0;
    while (ndone == 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    n_chk++;
    if (ndone == 0) begin
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", t);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_load(input string nm, input logic exp_err);
    int mism = 0;
    for (int i = 0; i < 242; i++) if (got_bits[i] !== exp_bits[i]) mism++;
    n_chk++;
    if (nbits != 242) begin
      n_fail++; $display("FAIL %s bit_count: got %0d required 242", nm, nbits);
    end
    n_chk++;
    if (mism != 0) begin
      n_fail++; $display("FAIL %s bitstream: %0d bits differ, required 0", nm, mism);
    end
    n_chk++;
    if ({got_bits[0], got_bits[1], got_bits[2], got_bits[3], got_bits[4], got_bits[5],
         got_bits[6], got_bits[7]} !== 8'b1010_0101) begin
      n_fail++; $display("FAIL %s first_bits: differ from 10100101", nm);
    end
    n_chk++;
    if ({got_bits[240], got_bits[241]} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s last_word_bits: got %b%b required 10", nm, got_bits[240], got_bits[241]);
    end
    n_chk++;
    if (nhs != n_words) begin
      n_fail++; $display("FAIL %s word_count: got %0d required %0d", nm, nhs, n_words);
    end
    n_chk++;
    if (ndone != 1) begin
      n_fail++; $display("FAIL %s done_pulses: got %0d required 1", nm, ndone);
    end
    n_chk++;
    if (err !== exp_err) begin
      n_fail++; $display("FAIL %s err: got %b required %b", nm, err, exp_err);
    end
    n_chk++;
    if (exp_err) begin
      if (napply != 0 || en_seen != 0) begin
        n_fail++;
        $display("FAIL %s apply_skipped: edges=%0d en_cycles=%0d required 0 0", nm, napply, en_seen);
      end
    end else if (napply != 4 || apply_bad != 0) begin
      n_fail++;
      $display("FAIL %s apply_periods: got %0d (bit1 on %0d) required 4 (0)", nm, napply, apply_bad);
    end
    n_chk++;
    if ({busy, cfg_en, cfg_clk, s_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s idle_after_done: busy/en/clk/ready=%b required 0000", nm,
               {busy, cfg_en, cfg_clk, s_ready});
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({s_ready, cfg_clk, cfg_bit, cfg_en, busy, done, err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {s_ready, cfg_clk, cfg_bit, cfg_en, busy, done, err});
    end
    n_chk++;
    if ({s_ready_s, cfg_clk_s, cfg_bit_s, cfg_en_s, busy_s, done_s, err_s} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_small: got %b required 0000000",
               {s_ready_s, cfg_clk_s, cfg_bit_s, cfg_en_s, busy_s, done_s, err_s});
    end
    res = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_load(-1, -1, -1, 8'h00);
    check_load("back_to_back", 1'b0);
  endtask

  task automatic test_stall();
    run_load(10, -1, -1, 8'h00);
    check_load("stall", 1'b0);
  endtask

  task automatic test_start_busy();
    run_load(-1, 15, -1, 8'h00);
    check_load("start_busy", 1'b0);
  endtask

  task automatic test_reset_mid();
    run_load(-1, -1, 4, 8'h00);
    run_load(-1, -1, -1, 8'h00);
    check_load("after_reset", 1'b0);
  endtask

  task automatic test_small();
    int         first_ready = -1, r1 = -1, r2 = -1, nb = 0, napp = 0, nd = 0;
    logic [8:0] bits = '0;
    logic       prev;
    @(posedge clk); #1;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s   = 1'b0;
    s_data_s  = 8'hFF;
    s_valid_s = 1'b1;
    @(posedge clk); #1;
    s_data_s = 8'h01;
    prev     = cfg_clk_s;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (cfg_clk_s && !prev) begin
        if (cfg_en_s) napp++;
        else begin
          if (nb < 9) bits[nb] = cfg_bit_s;
          nb++;
          if (r1 < 0) r1 = i;
          else if (r2 < 0) r2 = i;
        end
      end
      prev = cfg_clk_s;
      if (s_ready_s && first_ready < 0) first_ready = i;
      if (nb >= 9) s_data_s = crc9;
      if (done_s) nd++;
    end
    s_valid_s = 1'b0;
    n_chk++;
    if (first_ready != 16) begin
      n_fail++; $display("FAIL small_shift_cycles: got %0d required 16", first_ready);
    end
    n_chk++;
    if (r2 - r1 != 2) begin
      n_fail++; $display("FAIL small_cfg_clk_period: got %0d required 2", r2 - r1);
    end
    n_chk++;
    if (nb != 9 || bits !== 9'h1FF) begin
      n_fail++; $display("FAIL small_bits: got %0d bits %b required 9 bits 111111111", nb, bits);
    end
    n_chk++;
    if (napp != 4 || nd != 1) begin
      n_fail++; $display("FAIL small_apply_done: apply=%0d done=%0d required 4 1", napp, nd);
    end
  endtask

  task automatic test_crc();
`ifdef PAL_CFG_CRC_EN
    run_load(-1, -1, -1, 8'h01);
    check_load("crc_bad", 1'b1);
    run_load(-1, -1, -1, 8'h00);
    check_load("crc_good", 1'b0);
`else
    run_load(-1, -1, -1, 8'h01);
    check_load("no_crc", 1'b0);
`endif
  endtask

  initial begin
    res = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    start_s = 1'b0; s_valid_s = 1'b0; s_data_s = 8'h00;
    crc_big = 8'h00;
    for (int i = 0; i < 242; i++) begin
      exp_bits[i] = (8'hA5 >> (i % 8)) & 8'h01;
      crc_big = crc_step(crc_big, exp_bits[i]);
    end
    crc9 = 8'h00;
    for (int i = 0; i < 9; i++) crc9 = crc_step(crc9, 1'b1);
`ifdef PAL_CFG_CRC_EN
    n_words = 32;
`else
    n_words = 31;
`endif
    test_reset();
    test_back_to_back();
    test_stall();
    test_start_busy();
    test_reset_mid();
    test_small();
    test_crc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
